// File: rtl/lsu_pkg.sv
// Shared encodings for the data-memory port A load/store unit:
// RISC-V funct3 values, port-A strobe codes and the FSM state type.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] WE_NONE = 2'b00;
  localparam logic [1:0] WE_B    = 2'b01;
  localparam logic [1:0] WE_H    = 2'b10;
  localparam logic [1:0] WE_W    = 2'b11;

  // bit 2 = sign-extend, bits 1:0 = size; word reads must carry bit 2
  localparam logic [2:0] RE_NONE = 3'b000;
  localparam logic [2:0] RE_LB   = 3'b101;
  localparam logic [2:0] RE_LH   = 3'b110;
  localparam logic [2:0] RE_LW   = 3'b111;
  localparam logic [2:0] RE_LBU  = 3'b001;
  localparam logic [2:0] RE_LHU  = 3'b010;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD_WAIT = 2'd1,
    RESP      = 2'd2
  } lsu_state_e;

endpackage

// File: rtl/lsu_port_a_if.sv
// Core-side request/response channel of the port-A load/store unit.
// master = core (issues requests), slave = LSU.
interface lsu_port_a_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
);

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_store;
  logic [2:0]            req_funct3;
  logic [ADDR_WIDTH+1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic [4:0]            req_rd;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic [4:0]            rsp_rd;
  logic                  rsp_fault;
  logic [ADDR_WIDTH+1:0] rsp_badaddr;

  modport master (
    output req_valid, req_store, req_funct3, req_addr, req_wdata, req_rd, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_rd, rsp_fault, rsp_badaddr
  );

  modport slave (
    input  req_valid, req_store, req_funct3, req_addr, req_wdata, req_rd, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_rd, rsp_fault, rsp_badaddr
  );

endinterface

// File: rtl/lsu_decode.sv
// Combinational decode of a load/store request into port-A strobes and a fault flag.
// Faulting requests always produce zero strobes.
module lsu_decode
  import lsu_pkg::*;
(
  input  logic       store,
  input  logic [2:0] funct3,
  input  logic [1:0] addr_lo,
  output logic [1:0] we,
  output logic [2:0] re,
  output logic       fault
);

  logic illegal;
  logic misaligned;

  always_comb begin
    we         = WE_NONE;
    re         = RE_NONE;
    illegal    = 1'b0;
    misaligned = 1'b0;

    if (store) begin
      case (funct3)
        F3_B:    we = WE_B;
        F3_H:    we = WE_H;
        F3_W:    we = WE_W;
        default: illegal = 1'b1;
      endcase
    end else begin
      case (funct3)
        F3_B:    re = RE_LB;
        F3_H:    re = RE_LH;
        F3_W:    re = RE_LW;
        F3_BU:   re = RE_LBU;
        F3_HU:   re = RE_LHU;
        default: illegal = 1'b1;
      endcase
    end

    // funct3[1:0] is the access size for every legal encoding
    misaligned = ((funct3[1:0] == 2'b01) && addr_lo[0]) ||
                 ((funct3[1:0] == 2'b10) && (addr_lo != 2'b00));

    fault = illegal || misaligned;
    if (fault) begin
      we = WE_NONE;
      re = RE_NONE;
    end
  end

endmodule

// File: rtl/lsu_port_a.sv
// Single-outstanding load/store initiator on RAM port A. Strobes are driven
// combinationally in the accept cycle only, so each load pulses reA exactly once.
module lsu_port_a
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  lsu_port_a_if.slave           bus,
  output logic [1:0]            weA,
  output logic [2:0]            reA,
  output logic [ADDR_WIDTH+1:0] addrA,
  output logic [DATA_WIDTH-1:0] dinA,
  input  logic [DATA_WIDTH-1:0] doutA
);

  lsu_state_e            state_q, state_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [4:0]            rsp_rd_q, rsp_rd_d;
  logic                  rsp_fault_q, rsp_fault_d;
  logic [ADDR_WIDTH+1:0] rsp_badaddr_q, rsp_badaddr_d;

  logic [1:0] dec_we;
  logic [2:0] dec_re;
  logic       dec_fault;
  logic       accept;

  lsu_decode u_decode (
    .store   (bus.req_store),
    .funct3  (bus.req_funct3),
    .addr_lo (bus.req_addr[1:0]),
    .we      (dec_we),
    .re      (dec_re),
    .fault   (dec_fault)
  );

  assign bus.req_ready = (state_q == IDLE) && !rst;
  assign accept        = bus.req_valid && bus.req_ready;

  always_comb begin
    weA   = WE_NONE;
    reA   = RE_NONE;
    addrA = '0;
    dinA  = '0;
    if (accept && !dec_fault) begin
      weA   = dec_we;
      reA   = dec_re;
      addrA = bus.req_addr;
      dinA  = bus.req_store ? bus.req_wdata : '0;
    end
  end

  always_comb begin
    state_d       = state_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_rd_d      = rsp_rd_q;
    rsp_fault_d   = rsp_fault_q;
    rsp_badaddr_d = rsp_badaddr_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          rsp_rd_d      = bus.req_rd;
          rsp_badaddr_d = bus.req_addr;
          rsp_rdata_d   = '0;
          rsp_fault_d   = dec_fault;
          state_d       = (!bus.req_store && !dec_fault) ? LOAD_WAIT : RESP;
        end
      end
      // memory returns read data one cycle after reA
      LOAD_WAIT: begin
        rsp_rdata_d = doutA;
        rsp_fault_d = 1'b0;
        state_d     = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      rsp_rdata_q   <= '0;
      rsp_rd_q      <= '0;
      rsp_fault_q   <= 1'b0;
      rsp_badaddr_q <= '0;
    end else begin
      state_q       <= state_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_rd_q      <= rsp_rd_d;
      rsp_fault_q   <= rsp_fault_d;
      rsp_badaddr_q <= rsp_badaddr_d;
    end
  end

  assign bus.rsp_valid   = (state_q == RESP);
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.rsp_rd      = rsp_rd_q;
  assign bus.rsp_fault   = rsp_fault_q;
  assign bus.rsp_badaddr = rsp_badaddr_q;

endmodule

// File: tb/tb_lsu_port_a.sv
// Bench for lsu_port_a: byte-lane RAM model on port A, scoreboard of expected
// responses, per-transaction latency and strobe-pulse counting.
module tb_lsu_port_a;

  localparam int AW = 16;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lsu_port_a_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  logic [1:0]    weA;
  logic [2:0]    reA;
  logic [AW+1:0] addrA;
  logic [DW-1:0] dinA;
  logic [DW-1:0] doutA;

  lsu_port_a #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .weA   (weA),
    .reA   (reA),
    .addrA (addrA),
    .dinA  (dinA),
    .doutA (doutA)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Port-A memory model: byte lanes, little-endian, one-cycle read latency
  logic [7:0] mem [0:1023];
  initial for (int i = 0; i < 1024; i++) mem[i] = 8'h00;

  function automatic logic [31:0] mem_read(input logic [2:0] re, input logic [9:0] a);
    logic [31:0] v;
    v = 32'h0;
    case (re[1:0])
      2'b01: v = re[2] ? {{24{mem[a][7]}}, mem[a]} : {24'h0, mem[a]};
      2'b10: v = re[2] ? {{16{mem[a+1][7]}}, mem[a+1], mem[a]} : {16'h0, mem[a+1], mem[a]};
      2'b11: v = re[2] ? {mem[a+3], mem[a+2], mem[a+1], mem[a]} : 32'h0;
      default: v = 32'h0;
    endcase
    return v;
  endfunction

  always @(posedge clk) begin
    if (weA != 2'b00) begin
      mem[addrA[9:0]] <= dinA[7:0];
      if (weA != 2'b01) mem[addrA[9:0] + 10'd1] <= dinA[15:8];
      if (weA == 2'b11) begin
        mem[addrA[9:0] + 10'd2] <= dinA[23:16];
        mem[addrA[9:0] + 10'd3] <= dinA[31:24];
      end
    end
    doutA <= (reA != 3'b000) ? mem_read(reA, addrA[9:0]) : 32'h0;
  end

  int we_cnt = 0;
  int re_cnt = 0;
  always @(negedge clk) begin
    if (weA != 2'b00) we_cnt <= we_cnt + 1;
    if (reA != 3'b000) re_cnt <= re_cnt + 1;
  end

  typedef struct {
    logic [4:0]    rd;
    logic          fault;
    logic [31:0]   rdata;
    logic [AW+1:0] badaddr;
  } exp_t;
  exp_t expq[$];

  task automatic score_rsp();
    exp_t e;
    if (expq.size() == 0) begin
      check("unexpected_rsp", 64'(expq.size()), 64'd1);
      return;
    end
    e = expq.pop_front();
    check("rsp_rd", bus.rsp_rd, e.rd);
    check("rsp_fault", bus.rsp_fault, e.fault);
    check("rsp_rdata", bus.rsp_rdata, e.rdata);
    if (e.fault) check("rsp_badaddr", bus.rsp_badaddr, e.badaddr);
  endtask

  always @(negedge clk) begin
    if (!rst && bus.rsp_valid && bus.rsp_ready) score_rsp();
  end

  // One full transaction; hold>0 keeps rsp_ready low that many cycles while a
  // second request is presented and must be ignored.
  task automatic run_txn(input logic st, input logic [2:0] f3, input logic [AW+1:0] addr,
                         input logic [31:0] wd, input logic [4:0] rd, input logic flt,
                         input logic [1:0] ewe, input logic [2:0] ere,
                         input logic [31:0] erd, input int hold);
    int   we0, re0, lat;
    exp_t e;
    @(posedge clk); #1;
    bus.rsp_ready  = (hold == 0);
    bus.req_store  = st;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wd;
    bus.req_rd     = rd;
    bus.req_valid  = 1'b1;
    we0 = we_cnt;
    re0 = re_cnt;
    @(negedge clk);
    check("req_ready_idle", bus.req_ready, 1);
    check("weA_accept", weA, ewe);
    check("reA_accept", reA, ere);
    check("addrA_accept", addrA, flt ? '0 : addr);
    if (st) check("dinA_accept", dinA, flt ? 32'h0 : wd);
    e.rd = rd; e.fault = flt; e.rdata = erd; e.badaddr = addr;
    expq.push_back(e);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.rsp_valid && lat < 8);
    check("rsp_latency", lat, (!st && !flt) ? 2 : 1);
    if (hold > 0) begin
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        if (i == 0) begin
          bus.req_store  = 1'b0;
          bus.req_funct3 = 3'b100;
          bus.req_rd     = 5'd31;
          bus.req_valid  = 1'b1;
        end
        @(negedge clk);
        check("hold_rsp_valid", bus.rsp_valid, 1);
        check("hold_rsp_rdata", bus.rsp_rdata, erd);
        check("hold_req_ready", bus.req_ready, 0);
      end
      @(posedge clk); #1;
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      check("handshake_req_ready", bus.req_ready, 0);
    end
    @(posedge clk); #1;
    check("we_pulses", 64'(we_cnt - we0), (st && !flt) ? 64'd1 : 64'd0);
    check("re_pulses", 64'(re_cnt - re0), (!st && !flt) ? 64'd1 : 64'd0);
    if (hold > 0) begin
      @(negedge clk);
      check("post_handshake_req_ready", bus.req_ready, 1);
      bus.req_valid = 1'b0;
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_req_ready"}, bus.req_ready, 1);
    check({tag, "_rsp_valid"}, bus.rsp_valid, 0);
    check({tag, "_rsp_fault"}, bus.rsp_fault, 0);
    check({tag, "_rsp_rdata"}, bus.rsp_rdata, 0);
    check({tag, "_rsp_rd"}, bus.rsp_rd, 0);
    check({tag, "_rsp_badaddr"}, bus.rsp_badaddr, 0);
    check({tag, "_portA"}, {weA, reA, addrA, dinA}, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst            = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_store  = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.req_rd     = '0;
    bus.rsp_ready  = 1'b1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_req_ready", bus.req_ready, 0);
    check("reset_rsp_valid", bus.rsp_valid, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("reset");

    //      st    f3      addr      wdata         rd     flt   we     re      rdata         hold
    run_txn(1'b1, 3'b010, 18'h0100, 32'h12345678, 5'd1, 1'b0, 2'b11, 3'b000, 32'h00000000, 0);
    run_txn(1'b0, 3'b010, 18'h0100, 32'h0,        5'd2, 1'b0, 2'b00, 3'b111, 32'h12345678, 0);
    run_txn(1'b1, 3'b000, 18'h0103, 32'hCDEF55AB, 5'd3, 1'b0, 2'b01, 3'b000, 32'h00000000, 0);
    run_txn(1'b0, 3'b000, 18'h0103, 32'h0,        5'd4, 1'b0, 2'b00, 3'b101, 32'hFFFFFFAB, 0);
    run_txn(1'b0, 3'b100, 18'h0103, 32'h0,        5'd5, 1'b0, 2'b00, 3'b001, 32'h000000AB, 0);
    run_txn(1'b1, 3'b001, 18'h0102, 32'h00008001, 5'd6, 1'b0, 2'b10, 3'b000, 32'h00000000, 0);
    run_txn(1'b0, 3'b001, 18'h0102, 32'h0,        5'd7, 1'b0, 2'b00, 3'b110, 32'hFFFF8001, 0);
    run_txn(1'b0, 3'b101, 18'h0102, 32'h0,        5'd8, 1'b0, 2'b00, 3'b010, 32'h00008001, 0);
    // faults: misaligned and illegal funct3
    run_txn(1'b0, 3'b001, 18'h0101, 32'h0,        5'd9,  1'b1, 2'b00, 3'b000, 32'h0, 0);
    run_txn(1'b1, 3'b010, 18'h0102, 32'hDEADBEEF, 5'd10, 1'b1, 2'b00, 3'b000, 32'h0, 0);
    run_txn(1'b0, 3'b011, 18'h0100, 32'h0,        5'd11, 1'b1, 2'b00, 3'b000, 32'h0, 0);
    run_txn(1'b1, 3'b100, 18'h0100, 32'h11111111, 5'd12, 1'b1, 2'b00, 3'b000, 32'h0, 0);
    run_txn(1'b0, 3'b110, 18'h0104, 32'h0,        5'd13, 1'b1, 2'b00, 3'b000, 32'h0, 0);
    run_txn(1'b0, 3'b010, 18'h0103, 32'h0,        5'd14, 1'b1, 2'b00, 3'b000, 32'h0, 0);
    // backpressure: word at 0x100 is now 80 01 56 78
    run_txn(1'b0, 3'b010, 18'h0100, 32'h0,        5'd15, 1'b0, 2'b00, 3'b111, 32'h80015678, 5);
    run_txn(1'b0, 3'b100, 18'h0100, 32'h0,        5'd31, 1'b0, 2'b00, 3'b001, 32'h00000078, 0);

    // reset while in LOAD_WAIT abandons the load
    @(posedge clk); #1;
    bus.req_store  = 1'b0;
    bus.req_funct3 = 3'b010;
    bus.req_addr   = 18'h0100;
    bus.req_rd     = 5'd20;
    bus.req_valid  = 1'b1;
    @(negedge clk);
    check("rst_load_reA", reA, 3'b111);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_req_ready", bus.req_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("after_rst");
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rst_no_rsp", bus.rsp_valid, 0);
    end

    run_txn(1'b1, 3'b010, 18'h0104, 32'hA5A5A5A5, 5'd21, 1'b0, 2'b11, 3'b000, 32'h0, 0);
    run_txn(1'b0, 3'b010, 18'h0104, 32'h0,        5'd22, 1'b0, 2'b00, 3'b111, 32'hA5A5A5A5, 0);

    repeat (2) @(negedge clk);
    check("scoreboard_empty", 64'(expq.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
